// File: rtl/dmem_initiator.sv
// dmem_initiator
//   Initiator side of the data-memory handshake in the MIPS memory stage.
//   Accepts one load/store, presents it on the bus (memwrite/memread, byteen,
//   dataadr, lane-aligned writedata) one cycle later, holds it until dataack,
//   then returns the extended load result. Misaligned ops are rejected without
//   a bus cycle; an op with no ack for TIMEOUT busy cycles is abandoned.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   req_valid/write/size/signed/addr/wdata   memory-stage op (held while stall=1)
//   stall                 combinational pipeline hold
//   load_valid, load_data one-cycle load completion pulse and extended result
//   err_misalign          one-cycle pulse, op rejected
//   err_timeout           one-cycle pulse, op abandoned
//   memwrite, memread, byteen, dataadr, writedata   bus request (registered)
//   readdata, dataack     responder data and completion pulse
`timescale 1ns/1ps
module dmem_initiator #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        err_misalign,
  output logic        err_timeout,
  output logic        memwrite,
  output logic        memread,
  output logic [3:0]  byteen,
  output logic [31:0] dataadr,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        dataack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic              signed_q;
  logic              write_q;

  logic              load_valid_q;
  logic [31:0]       load_data_q;
  logic              err_misalign_q;
  logic              err_timeout_q;
  logic              memwrite_q;
  logic              memread_q;
  logic [3:0]        byteen_q;
  logic [31:0]       dataadr_q;
  logic [31:0]       writedata_q;

  logic              misaligned;
  logic [3:0]        lane_en;
  logic [31:0]       lane_data;
  logic [4:0]        rd_sh_amt;
  logic [31:0]       rd_shift;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       load_ext;

  assign misaligned = (req_size == 2'b11) ||
                      ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Big-endian lanes: byte offset k maps to byteen[3-k].
  always_comb begin
    lane_en   = 4'b1111;
    lane_data = req_wdata;
    case (req_size)
      2'b00: begin
        lane_en   = 4'b1000 >> req_addr[1:0];
        lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = req_addr[1] ? 4'b0011 : 4'b1100;
        lane_data = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = req_wdata;
      end
    endcase
  end

  // Offset k lives in bits [31-8k -: 8]; shift it down to the bottom byte.
  assign rd_sh_amt = {2'd3 - off_q, 3'b000};
  assign rd_shift  = readdata >> rd_sh_amt;
  assign ld_byte   = rd_shift[7:0];
  assign ld_half   = off_q[1] ? readdata[15:0] : readdata[31:16];

  always_comb begin
    load_ext = readdata;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{signed_q & ld_half[15]}}, ld_half};
      default: load_ext = readdata;
    endcase
  end

  // DONE deliberately ignores req_valid: it is still the op just completed.
  assign stall = ((state_q == S_IDLE) && req_valid && !misaligned) ||
                 (state_q == S_BUSY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      size_q         <= 2'b00;
      off_q          <= 2'b00;
      signed_q       <= 1'b0;
      write_q        <= 1'b0;
      load_valid_q   <= 1'b0;
      load_data_q    <= 32'h0;
      err_misalign_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      memwrite_q     <= 1'b0;
      memread_q      <= 1'b0;
      byteen_q       <= 4'b0000;
      dataadr_q      <= 32'h0;
      writedata_q    <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          load_valid_q   <= 1'b0;
          err_timeout_q  <= 1'b0;
          err_misalign_q <= req_valid && misaligned;
          if (req_valid && !misaligned) begin
            memwrite_q  <= req_write;
            memread_q   <= !req_write;
            byteen_q    <= lane_en;
            dataadr_q   <= {req_addr[31:2], 2'b00};
            writedata_q <= lane_data;
            size_q      <= req_size;
            off_q       <= req_addr[1:0];
            signed_q    <= req_signed;
            write_q     <= req_write;
            cnt_q       <= '0;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          // The ack is tested first so it wins over a coincident timeout.
          if (dataack) begin
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            byteen_q   <= 4'b0000;
            if (!write_q) begin
              load_data_q  <= load_ext;
              load_valid_q <= 1'b1;
            end
            state_q <= S_DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            memwrite_q    <= 1'b0;
            memread_q     <= 1'b0;
            byteen_q      <= 4'b0000;
            err_timeout_q <= 1'b1;
            state_q       <= S_DONE;
          end
        end
        S_DONE: begin
          load_valid_q  <= 1'b0;
          err_timeout_q <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign load_valid   = load_valid_q;
  assign load_data    = load_data_q;
  assign err_misalign = err_misalign_q;
  assign err_timeout  = err_timeout_q;
  assign memwrite     = memwrite_q;
  assign memread      = memread_q;
  assign byteen       = byteen_q;
  assign dataadr      = dataadr_q;
  assign writedata    = writedata_q;

endmodule

// File: tb/tb_dmem_initiator.sv
`timescale 1ns/1ps
module tb_dmem_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, load_valid, err_misalign, err_timeout;
  logic [31:0] load_data;
  logic        memwrite, memread;
  logic [3:0]  byteen;
  logic [31:0] dataadr, writedata;
  logic [31:0] readdata;
  logic        dataack;

  dmem_initiator #(.TIMEOUT(64), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_valid(load_valid), .load_data(load_data),
    .err_misalign(err_misalign), .err_timeout(err_timeout),
    .memwrite(memwrite), .memread(memread), .byteen(byteen),
    .dataadr(dataadr), .writedata(writedata),
    .readdata(readdata), .dataack(dataack)
  );

  always #5 clk = ~clk;

  localparam int TMO = 64;
  localparam int K_LOAD = 0, K_MIS = 1, K_TMO = 2;

  typedef struct { bit wr; logic [3:0] be; logic [31:0] adr; logic [31:0] wd; } req_t;
  typedef struct { int kind; logic [31:0] data; } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  int          cur_lat = 0;
  logic [31:0] cur_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'd3) return 1'b1;
    return (addr % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] m_byteen(input logic [1:0] sz, input logic [1:0] off);
    int n = 1 << sz;
    logic [3:0] be = 4'b0;
    for (int k = int'(off); k < int'(off) + n; k++) be[3-k] = 1'b1;
    return be;
  endfunction

  // Every lane carries the store byte that would land there if the value
  // were repeated across the word in big-endian order.
  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    int n = 1 << sz;
    logic [31:0] r = 32'h0;
    for (int k = 0; k < 4; k++) begin
      int idx = n - 1 - (k % n);
      r[31-8*k -: 8] = wd[8*idx +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] off,
                                         input bit sg, input logic [31:0] rd);
    int n = 1 << sz;
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, rd[31-8*(int'(off)+i) -: 8]};
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  // ---------------- responder ----------------
  initial begin
    dataack  = 1'b0;
    readdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (!reset && (memread || memwrite)) begin
        if (cur_lat >= 0) begin
          repeat (cur_lat) @(negedge clk);
          dataack  = 1'b1;
          readdata = cur_rdata;
          @(negedge clk);
          dataack  = 1'b0;
          readdata = $urandom;
        end else begin
          for (int w = 0; w < 400 && (memread || memwrite); w++) @(negedge clk);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit          prev_req;
    bit          req_now;
    req_t        e;
    resp_t       r;
    logic        h_mw, h_mr;
    logic [3:0]  h_be;
    logic [31:0] h_adr, h_wd;
    prev_req = 1'b0;
    h_mw = 1'b0; h_mr = 1'b0; h_be = 4'b0; h_adr = 32'h0; h_wd = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
      end else begin
        req_now = memread || memwrite;
        if (req_now && !prev_req) begin
          if (req_q.size() == 0) begin
            check("unexpected_request", 32'd1, 32'd0);
          end else begin
            e = req_q.pop_front();
            check("memwrite", memwrite, e.wr);
            check("memread", memread, !e.wr);
            check("byteen", byteen, e.be);
            check("dataadr", dataadr, e.adr);
            if (e.wr) check("writedata", writedata, e.wd);
          end
          h_mw = memwrite; h_mr = memread; h_be = byteen; h_adr = dataadr; h_wd = writedata;
        end else if (req_now) begin
          check("bus_held", {h_mw, h_mr, h_be, h_adr[25:0]} ^ {memwrite, memread, byteen, dataadr[25:0]}
                ^ (h_wd ^ writedata) ^ {h_adr[31:26] ^ dataadr[31:26], 26'h0}, 32'h0);
        end
        prev_req = req_now;

        if (load_valid || err_misalign || err_timeout) begin
          if ($countones({load_valid, err_misalign, err_timeout}) > 1) begin
            check("multiple_pulses", {29'h0, load_valid, err_misalign, err_timeout}, 32'h0);
          end else if (resp_q.size() == 0) begin
            check("unexpected_pulse", {29'h0, load_valid, err_misalign, err_timeout}, 32'h0);
          end else begin
            r = resp_q.pop_front();
            check("pulse_kind", load_valid ? K_LOAD : (err_misalign ? K_MIS : K_TMO), r.kind);
            if (r.kind == K_LOAD && load_valid) check("load_data", load_data, r.data);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_op(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int lat);
    bit    mis;
    int    exp_stall;
    int    stall_cnt;
    bit    done;
    bit    s;
    req_t  e;
    resp_t r;
    mis = m_misaligned(sz, addr);
    if (mis) begin
      exp_stall = 0;
      r.kind = K_MIS; r.data = 32'h0;
      resp_q.push_back(r);
    end else begin
      e.wr = wr; e.be = m_byteen(sz, addr[1:0]); e.adr = addr & 32'hFFFF_FFFC;
      e.wd = m_wdata(sz, wd);
      req_q.push_back(e);
      if (lat < 0 || lat >= TMO) begin
        exp_stall = 1 + TMO;
        r.kind = K_TMO; r.data = 32'h0;
        resp_q.push_back(r);
      end else begin
        exp_stall = lat + 2;
        if (!wr) begin
          r.kind = K_LOAD; r.data = m_load(sz, addr[1:0], sg, rd);
          resp_q.push_back(r);
        end
      end
    end
    cur_lat   = lat;
    cur_rdata = rd;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr  = addr; req_wdata = wd;
    stall_cnt = 0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      s = stall;
      if (s) stall_cnt++;
      @(posedge clk);
      #1;
      if (!s) done = 1'b1;
    end
    if (!done) check("op_completion_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
    check("stall_cycles", stall_cnt, exp_stall);
    $display("op wr=%0d size=%0d sgn=%0d addr=%h wdata=%h rdata=%h lat=%0d stall=%0d",
             wr, sz, sg, addr, wd, rd, lat, stall_cnt);
  endtask

  initial begin
    req_t e;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_memwrite", memwrite, 1'b0);
    check("rst_memread", memread, 1'b0);
    check("rst_byteen", byteen, 4'b0);
    check("rst_dataadr", dataadr, 32'h0);
    check("rst_writedata", writedata, 32'h0);
    check("rst_load_valid", load_valid, 1'b0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_pulses", {err_misalign, err_timeout}, 2'b00);
    reset = 1'b0;
    @(posedge clk); #1;

    // directed cases
    do_op(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00A5, 32'h0, 2);
    do_op(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 32'h1234_8001, 1);
    do_op(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 32'h1234_8001, 0);
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_0003, 32'h0, 32'h0, 0);
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h5555_AAAA, -1);
    do_op(1'b0, 2'b00, 1'b1, 32'h0000_0051, 32'h0, 32'h12F4_5678, TMO - 1);
    do_op(1'b1, 2'b11, 1'b0, 32'h0000_0060, 32'h1, 32'h0, 0);

    // reset two cycles into BUSY
    e.wr = 1'b1; e.be = 4'b1111; e.adr = 32'h0000_0080; e.wd = 32'hCAFE_F00D;
    req_q.push_back(e);
    cur_lat = -1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0000_0080; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_memwrite", memwrite, 1'b0);
    check("rstmid_byteen", byteen, 4'b0);
    req_valid = 1'b0;
    #1;
    check("rstmid_stall", stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rstmid_idle_no_req", {memwrite, memread}, 2'b00);
    $display("op reset_mid_busy addr=00000080");

    // randomized ops
    for (int i = 0; i < 80; i++) begin
      bit          wr, sg;
      logic [1:0]  sz;
      logic [31:0] addr, wd, rd;
      int          lat;
      wr   = 1'($urandom_range(0, 1));
      sg   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom;
      wd   = $urandom;
      rd   = $urandom;
      lat  = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
      do_op(wr, sz, sg, addr, wd, rd, lat);
    end

    repeat (4) @(posedge clk);
    check("req_queue_drained", req_q.size(), 32'd0);
    check("resp_queue_drained", resp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
